instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 27 ++
 rtl/instruction_fetch_unit_fetch_buffer.sv | 69 ++++++
 rtl/instruction_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its fetch buffer.
package instruction_fetch_unit_pkg;

    localparam int          INST_WIDTH           = 32;
    localparam int          PC_WIDTH             = 32;
    localparam logic [31:0] PC_STEP              = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // IDLE is a single settling cycle after reset, HALT is only left through reset.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    // One fetch buffer entry: the fetch address and the word memory returned for it.
    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

    // Instruction addresses must be word aligned.
    function automatic logic isAligned(input logic [PC_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Two-entry in-order fetch buffer. The head entry sits in its own register so
// the decode-side outputs stay stable until the entry is popped.
module fetch_buffer
    import instruction_fetch_unit_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t entry_i,
    output logic [1:0]   count_o,
    output logic         valid_o,
    output fetch_entry_t head_o
);

    fetch_entry_t head_q;
    fetch_entry_t tail_q;
    logic [1:0]   count_q;
    logic         doPush;
    logic         doPop;

    // The buffer protects itself against popping when empty or pushing when full
    // without a simultaneous pop.
    assign doPop  = pop_i && (count_q != 2'd0);
    assign doPush = push_i && ((count_q != 2'd2) || doPop);

    // Shift-style storage: a pop moves the tail into the head, a push fills the
    // first free slot; flush only clears the occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else if (flush_i) begin
            count_q <= 2'd0;
        end else begin
            case ({doPush, doPop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= entry_i;
                    end else begin
                        tail_q <= entry_i;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= entry_i;
                    end else begin
                        head_q <= entry_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);
    assign head_o  = head_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks the PC through instruction memory, queues
// fetched words for decode in a two-entry buffer, and handles redirects.
// A misaligned redirect parks the unit in HALT until reset.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
)
(
    input  logic                  CLK,
    input  logic                  RESET,
    output logic [PC_WIDTH-1:0]   PC,
    input  logic [INST_WIDTH-1:0] INST_CODE,
    input  logic                  REDIRECT_VALID,
    input  logic [PC_WIDTH-1:0]   REDIRECT_PC,
    input  logic                  DEC_READY,
    output logic                  DEC_VALID,
    output logic [INST_WIDTH-1:0] DEC_INST,
    output logic [PC_WIDTH-1:0]   DEC_PC,
    output logic                  MISALIGN
);

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   pc_d;
    logic                  misalign_q;
    logic                  misalign_d;

    logic                  push;
    logic                  pop;
    logic                  flush;
    logic [1:0]            bufCount;
    logic                  bufValid;
    fetch_entry_t          bufHead;
    fetch_entry_t          pushEntry;

    assign pushEntry = {pc_q, INST_CODE};

    // Next-state decode: a redirect outranks push and pop, otherwise fetch
    // whenever the buffer has, or is about to have, a free slot.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        push       = 1'b0;
        flush      = 1'b0;
        pop        = bufValid && DEC_READY;
        case (state_q)
            ST_IDLE: begin
                if (REDIRECT_VALID) begin
                    flush = 1'b1;
                    pop   = 1'b0;
                    if (isAligned(REDIRECT_PC)) begin
                        pc_d    = REDIRECT_PC;
                        state_d = ST_FETCH;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (REDIRECT_VALID) begin
                    flush = 1'b1;
                    pop   = 1'b0;
                    if (isAligned(REDIRECT_PC)) begin
                        pc_d = REDIRECT_PC;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end
                end else if ((bufCount != 2'd2) || pop) begin
                    push = 1'b1;
                    pc_d = pc_q + PC_STEP;
                end
            end
            ST_HALT: begin
                pop = 1'b0;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Control state, fetch address and the sticky misalign flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .entry_i (pushEntry),
        .count_o (bufCount),
        .valid_o (bufValid),
        .head_o  (bufHead)
    );

    assign PC        = pc_q;
    assign DEC_VALID = bufValid;
    assign DEC_INST  = bufHead.inst;
    assign DEC_PC    = bufHead.pc;
    assign MISALIGN  = misalign_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios with a scoreboard
// of expected decode transfers and direct checks of PC, DEC_VALID and MISALIGN.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } expEntry_t;

    logic        clk;
    logic        resetN;
    logic [31:0] pc;
    logic [31:0] instCode;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        decReady;
    logic        decValid;
    logic [31:0] decInst;
    logic [31:0] decPc;
    logic        misalign;

    logic [31:0] mem [0:1023];
    expEntry_t   expQ [$];
    expEntry_t   headExp;
    int          testsRun    = 0;
    int          testsFailed = 0;

    instruction_fetch_unit #(
        .RESET_VECTOR (RESET_VEC)
    ) dut (
        .CLK            (clk),
        .RESET          (resetN),
        .PC             (pc),
        .INST_CODE      (instCode),
        .REDIRECT_VALID (redirectValid),
        .REDIRECT_PC    (redirectPc),
        .DEC_READY      (decReady),
        .DEC_VALID      (decValid),
        .DEC_INST       (decInst),
        .DEC_PC         (decPc),
        .MISALIGN       (misalign)
    );

    // Instruction memory: word array indexed by PC[31:2]; addresses above the
    // modelled 4 KiB region read back a fixed marker word.
    always_comb begin
        if (pc[31:12] == 20'h0) begin
            instCode = mem[pc[11:2]];
        end else begin
            instCode = 32'hDEAD_BEEF;
        end
    end

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a scenario never completes.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirectValid = rv;
        redirectPc    = rpc;
        decReady      = rdy;
    endtask

    task automatic expectEntry(input logic [31:0] p, input logic [31:0] i);
        expQ.push_back({p, i});
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Waits until the monitor has consumed every expected entry, returning just
    // after the clock edge that performs the last pop.
    task automatic drainExpected(input int maxCycles, input string name);
        int n = 0;
        while ((expQ.size() != 0) && (n < maxCycles)) begin
            @(posedge clk);
            n++;
        end
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL %s: %0d entries still pending after %0d cycles, expected 0", name, expQ.size(), maxCycles);
            expQ.delete();
        end
        #1;
    endtask

    // Scoreboard monitor: every accepted decode transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (resetN && decValid && decReady) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedTransfer: got pc %h inst %h, expected no transfer", decPc, decInst);
            end else begin
                headExp = expQ.pop_front();
                checkOutput("scoreboardPc", decPc, headExp.pc);
                checkOutput("scoreboardInst", decInst, headExp.inst);
            end
        end
    end

    // Directed scenario sequence.
    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h0000_0013 | (32'(i) << 20);
        end
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0020_81B3;

        applyStimulus(1'b0, 32'h0, 1'b1);
        resetN = 1'b1;
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("resetPc", pc, RESET_VEC);
        checkOutput("resetDecValid", 32'(decValid), 32'd0);
        checkOutput("resetDecInst", decInst, 32'h0);
        checkOutput("resetDecPc", decPc, 32'h0);
        checkOutput("resetMisalign", 32'(misalign), 32'd0);

        // Reset-and-stream
        expectEntry(32'h0, 32'h0050_0093);
        expectEntry(32'h4, 32'h00A0_0113);
        expectEntry(32'h8, 32'h0020_81B3);
        @(negedge clk);
        #1;
        resetN = 1'b1;
        @(negedge clk);
        checkOutput("idleNoPush", 32'(decValid), 32'd0);
        @(negedge clk);
        checkOutput("firstValid", 32'(decValid), 32'd1);
        checkOutput("firstPc", decPc, 32'h0);
        @(negedge clk);
        checkOutput("secondValid", 32'(decValid), 32'd1);
        checkOutput("secondPc", decPc, 32'h4);
        @(negedge clk);
        checkOutput("thirdValid", 32'(decValid), 32'd1);
        checkOutput("thirdPc", decPc, 32'h8);
        nextCycle();
        checkOutput("streamConsumed", 32'(expQ.size()), 32'd0);

        // Asynchronous reset mid-stream with a valid head entry
        applyStimulus(1'b0, 32'h0, 1'b0);
        resetN = 1'b0;
        #1;
        checkOutput("asyncResetPc", pc, RESET_VEC);
        checkOutput("asyncResetDecValid", 32'(decValid), 32'd0);
        checkOutput("asyncResetDecPc", decPc, 32'h0);

        // Backpressure
        @(negedge clk);
        #1;
        resetN = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("stallDecValid", 32'(decValid), 32'd1);
            checkOutput("stallDecPc", decPc, 32'h0);
        end
        checkOutput("stallPcHold", pc, 32'h8);
        expectEntry(32'h0, 32'h0050_0093);
        expectEntry(32'h4, 32'h00A0_0113);
        expectEntry(32'h8, 32'h0020_81B3);
        expectEntry(32'hC, 32'h0030_0013);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        drainExpected(20, "resumeDrain");
        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("fullDecValid", 32'(decValid), 32'd1);
        checkOutput("fullDecPc", decPc, 32'h10);
        checkOutput("fullPc", pc, 32'h18);

        // Redirect with a full buffer
        nextCycle();
        applyStimulus(1'b1, 32'h40, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("redirectFlushValid", 32'(decValid), 32'd0);
        checkOutput("redirectPc", pc, 32'h40);
        @(negedge clk);
        checkOutput("redirectHeadValid", 32'(decValid), 32'd1);
        checkOutput("redirectHeadPc", decPc, 32'h40);
        checkOutput("redirectHeadInst", decInst, 32'h0100_0013);
        expectEntry(32'h40, 32'h0100_0013);
        expectEntry(32'h44, 32'h0110_0013);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        drainExpected(20, "redirectDrain");
        applyStimulus(1'b1, 32'h42, 1'b0);

        // Misaligned redirect, then ignored aligned redirect while halted
        nextCycle();
        applyStimulus(1'b1, 32'h80, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("haltDecValid", 32'(decValid), 32'd0);
            checkOutput("haltPc", pc, 32'h50);
            checkOutput("haltMisalign", 32'(misalign), 32'd1);
        end
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        resetN = 1'b0;
        #1;
        checkOutput("resetClearsMisalign", 32'(misalign), 32'd0);
        checkOutput("resetAfterHaltPc", pc, RESET_VEC);

        // Redirect during IDLE to the last word, then wrap to zero
        nextCycle();
        resetN = 1'b1;
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("wrapTargetPc", pc, 32'hFFFF_FFFC);
        checkOutput("wrapTargetDecValid", 32'(decValid), 32'd0);
        @(negedge clk);
        checkOutput("wrapPc", pc, 32'h0);
        checkOutput("wrapHeadPc", decPc, 32'hFFFF_FFFC);
        checkOutput("wrapHeadInst", decInst, 32'hDEAD_BEEF);
        expectEntry(32'hFFFF_FFFC, 32'hDEAD_BEEF);
        expectEntry(32'h0, 32'h0050_0093);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        drainExpected(20, "wrapDrain");
        applyStimulus(1'b0, 32'h0, 1'b0);

        nextCycle();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
